// File: rtl/dsp_collect_pkg.sv
// Shared definitions for the DSP result collector: mode latency constants,
// tag-pipeline depth and tag/result-entry types. Optional macro: DSP_COLLECT_SEQ_EN.
`default_nettype none

package dsp_collect_pkg;

  localparam logic [1:0] E_MODE0      = 2'd0;
  localparam logic [1:0] E_MODE1      = 2'd1;
  localparam logic [1:0] E_MODE2      = 2'd3;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  // Longest possible latency: 1 + E(2) + (2^psw - 1).
  function automatic int max_lat(input int psw);
    return 4 + (1 << psw) - 1;
  endfunction

  function automatic logic [1:0] mode_extra(input logic [1:0] mode);
    case (mode)
      2'd0:    return E_MODE0;
      2'd1:    return E_MODE1;
      2'd2:    return E_MODE2;
      default: return 2'd0;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0] mode;
    logic       mac;
`ifdef DSP_COLLECT_SEQ_EN
    logic [3:0] seq;
`endif
  } res_meta_t;

  typedef struct packed {
    logic      valid;
    res_meta_t meta;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/dsp_collect_fifo.sv
// First-word fall-through FIFO with full/empty flags; head reads as zero when empty.
`default_nettype none

module dsp_collect_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dsp_result_collector.sv
// Tracks issued DSP operations through a latency tag pipeline and captures each
// result into a FIFO. Optional macro DSP_COLLECT_SEQ_EN adds a res_seq tag.
`default_nettype none

module dsp_result_collector #(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic                        mac,
  input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
  input  logic [2*WIDTH-1:0]          dsp_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [2*WIDTH-1:0]          res_data,
  output logic [1:0]                  res_mode,
  output logic                        res_mac,
  output logic [3:0]                  in_flight,
  output logic                        err_ovf,
  output logic                        err_coll,
`ifdef DSP_COLLECT_SEQ_EN
  output logic [3:0]                  res_seq,
`endif
  output logic                        err_mode
);

  import dsp_collect_pkg::*;

  localparam int MAX_LAT = max_lat(PIPE_STAGE_WIDTH);
  localparam int SW      = $clog2(MAX_LAT);
  localparam int META_W  = $bits(res_meta_t);
  localparam int DATA_W  = 2*WIDTH + META_W;

  tag_t              tags_q [MAX_LAT];
  tag_t              tags_d [MAX_LAT];
  logic [SW-1:0]     tgt;
  logic              ins;
  logic              coll;
  logic              cap;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [3:0]        in_flight_q, in_flight_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_coll_q, err_coll_d;
  logic              err_mode_q, err_mode_d;
  res_meta_t         new_meta;
  res_meta_t         head_meta;
  logic [DATA_W-1:0] fifo_din;
  logic [DATA_W-1:0] fifo_dout;
`ifdef DSP_COLLECT_SEQ_EN
  logic [3:0]        seq_q, seq_d;
`endif

  // Target slot is L-1 = E(mode) + pipe_stages.
  assign tgt = SW'(mode_extra(mode)) + SW'(pipe_stages);

  always_comb begin
    new_meta      = '0;
    new_meta.mode = mode;
    new_meta.mac  = mac;
`ifdef DSP_COLLECT_SEQ_EN
    new_meta.seq  = seq_q;
`endif
  end

  // Shift first, then insert; an occupied target keeps the older tag.
  always_comb begin
    for (int i = 0; i < MAX_LAT-1; i++) begin
      tags_d[i] = tags_q[i+1];
    end
    tags_d[MAX_LAT-1] = '0;
    ins  = 1'b0;
    coll = 1'b0;
    if (start && (mode != MODE_INVALID)) begin
      if (tags_d[tgt].valid) begin
        coll = 1'b1;
      end else begin
        tags_d[tgt].valid = 1'b1;
        tags_d[tgt].meta  = new_meta;
        ins               = 1'b1;
      end
    end
  end

  assign cap      = tags_q[0].valid;
  assign fifo_din = {dsp_out, tags_q[0].meta};
  assign pop      = res_valid && res_ready;

  always_comb begin
    in_flight_d = in_flight_q;
    if (ins && !cap && (in_flight_q != 4'hF)) begin
      in_flight_d = in_flight_q + 4'd1;
    end else if (cap && !ins && (in_flight_q != 4'h0)) begin
      in_flight_d = in_flight_q - 4'd1;
    end
    err_ovf_d  = err_ovf_q  | (cap && fifo_full && !pop);
    err_coll_d = err_coll_q | coll;
    err_mode_d = err_mode_q | (start && (mode == MODE_INVALID));
`ifdef DSP_COLLECT_SEQ_EN
    seq_d = ins ? seq_q + 4'd1 : seq_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        tags_q[i] <= '0;
      end
      in_flight_q <= '0;
      err_ovf_q   <= 1'b0;
      err_coll_q  <= 1'b0;
      err_mode_q  <= 1'b0;
`ifdef DSP_COLLECT_SEQ_EN
      seq_q       <= '0;
`endif
    end else begin
      tags_q      <= tags_d;
      in_flight_q <= in_flight_d;
      err_ovf_q   <= err_ovf_d;
      err_coll_q  <= err_coll_d;
      err_mode_q  <= err_mode_d;
`ifdef DSP_COLLECT_SEQ_EN
      seq_q       <= seq_d;
`endif
    end
  end

  dsp_collect_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_meta = fifo_dout[META_W-1:0];
  assign res_valid = !fifo_empty;
  assign res_data  = fifo_dout[DATA_W-1 -: 2*WIDTH];
  assign res_mode  = head_meta.mode;
  assign res_mac   = head_meta.mac;
`ifdef DSP_COLLECT_SEQ_EN
  assign res_seq   = head_meta.seq;
`endif
  assign in_flight = in_flight_q;
  assign err_ovf   = err_ovf_q;
  assign err_coll  = err_coll_q;
  assign err_mode  = err_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_result_collector.sv
// Self-checking bench for dsp_result_collector: directed scenarios plus a
// randomized run against a scheduled-operation reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_dsp_result_collector;

  localparam int WIDTH = 16;
  localparam int PSW   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic           mac = 1'b0;
  logic [PSW-1:0] pipe_stages = '0;
  logic [31:0]    dsp_out = '0;
  logic           res_ready = 1'b0;
  logic           res_valid;
  logic [31:0]    res_data;
  logic [1:0]     res_mode;
  logic           res_mac;
  logic [3:0]     in_flight;
  logic           err_ovf;
  logic           err_coll;
  logic           err_mode;
`ifdef DSP_COLLECT_SEQ_EN
  logic [3:0]     res_seq;
`endif

  always #5 clk = ~clk;

  dsp_result_collector #(
    .WIDTH            (WIDTH),
    .PIPE_STAGE_WIDTH (PSW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .mac         (mac),
    .pipe_stages (pipe_stages),
    .dsp_out     (dsp_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_mode    (res_mode),
    .res_mac     (res_mac),
    .in_flight   (in_flight),
    .err_ovf     (err_ovf),
    .err_coll    (err_coll),
`ifdef DSP_COLLECT_SEQ_EN
    .res_seq     (res_seq),
`endif
    .err_mode    (err_mode)
  );

  // Reference model: each tracked op is scheduled at an absolute capture edge.
  typedef struct { int due; logic [1:0] mode; logic mac; } op_t;
  typedef struct { logic [31:0] data; logic [1:0] mode; logic mac; } ent_t;

  op_t  pend[$];
  ent_t fq[$];
  int   cyc = 0;
  bit   m_ovf, m_coll, m_mode;
  int   e_tab[4] = '{0, 1, 3, 0};
  int   checks = 0;
  int   errors = 0;

  task automatic model_clear();
    pend.delete();
    fq.delete();
    m_ovf  = 1'b0;
    m_coll = 1'b0;
    m_mode = 1'b0;
  endtask

  task automatic model_edge();
    bit   pop;
    int   k;
    int   sz;
    int   due;
    bit   hit;
    ent_t e;
    cyc++;
    pop = (fq.size() > 0) && res_ready;
    k = -1;
    for (int i = 0; i < pend.size(); i++) if (pend[i].due == cyc) k = i;
    sz = fq.size();
    if (pop) void'(fq.pop_front());
    if (k >= 0) begin
      e.data = dsp_out;
      e.mode = pend[k].mode;
      e.mac  = pend[k].mac;
      pend.delete(k);
      if (sz == DEPTH && !pop) m_ovf = 1'b1;
      else fq.push_back(e);
    end
    if (start) begin
      if (mode == 2'd3) begin
        m_mode = 1'b1;
      end else begin
        due = cyc + 1 + e_tab[mode] + int'(pipe_stages);
        hit = 1'b0;
        foreach (pend[i]) if (pend[i].due == due) hit = 1'b1;
        if (hit) m_coll = 1'b1;
        else pend.push_back('{due, mode, mac});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; mode = '0; mac = 1'b0; pipe_stages = '0; res_ready = 1'b0; dsp_out = '0;
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({res_valid, res_mode, res_mac, in_flight} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: got %h expected 00", {res_valid, res_mode, res_mac, in_flight});
    end
    checks++;
    if ({res_data, err_ovf, err_coll, err_mode} !== 35'h0) begin
      errors++;
      $display("FAIL reset_data_err: got %h expected 0", {res_data, err_ovf, err_coll, err_mode});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    mode = 2'd0; pipe_stages = '0; mac = 1'b1; start = 1'b1;
    step();
    start = 1'b0; dsp_out = 32'h0000_1234;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: res_valid got %b expected 0", res_valid);
    end
    step();
    checks++;
    if ({res_valid, res_data, res_mode, res_mac} !== {1'b1, 32'h0000_1234, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL basic_capture: got v=%b d=%h m=%0d mac=%b expected v=1 d=00001234 m=0 mac=1",
               res_valid, res_data, res_mode, res_mac);
    end
    dsp_out = '0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pop: res_valid got %b expected 0", res_valid);
    end
  endtask

  task automatic test_latency();
    do_reset();
    mode = 2'd2; pipe_stages = 2'd3; mac = 1'b0; start = 1'b1;
    step();
    start = 1'b0; pipe_stages = 2'd0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (in_flight !== 4'd1 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_wait%0d: in_flight=%0d valid=%b expected 1/0", i, in_flight, res_valid);
      end
      dsp_out = (i == 6) ? 32'hCAFE_0007 : 32'h0;
      step();
    end
    checks++;
    if ({res_valid, res_data, res_mode, in_flight} !== {1'b1, 32'hCAFE_0007, 2'd2, 4'd0}) begin
      errors++;
      $display("FAIL latency_capture: got v=%b d=%h m=%0d if=%0d expected v=1 d=cafe0007 m=2 if=0",
               res_valid, res_data, res_mode, in_flight);
    end
    dsp_out = '0;
  endtask

  task automatic test_collision();
    do_reset();
    mode = 2'd2; pipe_stages = '0; mac = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    mode = 2'd0; mac = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (err_coll !== 1'b1) begin
      errors++; $display("FAIL coll_flag: err_coll got %b expected 1", err_coll);
    end
    repeat (3) step();
    checks++;
    if ({res_valid, res_mode, res_mac, in_flight} !== {1'b1, 2'd2, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL coll_entry: got v=%b m=%0d mac=%b if=%0d expected v=1 m=2 mac=0 if=0",
               res_valid, res_mode, res_mac, in_flight);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL coll_single: res_valid got %b expected 0", res_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    mode = 2'd0; pipe_stages = '0;
    for (int i = 0; i < 6; i++) begin
      start   = (i < 5);
      dsp_out = 32'hA0 + i;
      step();
    end
    start = 1'b0;
    checks++;
    if ({err_ovf, res_valid, in_flight} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL ovf_flag: got ovf=%b v=%b if=%0d expected 1/1/0", err_ovf, res_valid, in_flight);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'hA1 + k) begin
        errors++;
        $display("FAIL ovf_order%0d: got v=%b d=%h expected v=1 d=%h", k, res_valid, res_data, 32'hA1 + k);
      end
      step();
    end
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain: res_valid got %b expected 0", res_valid);
    end
  endtask

  task automatic test_mode3();
    do_reset();
    mode = 2'd3; start = 1'b1;
    step();
    start = 1'b0; mode = 2'd0;
    checks++;
    if ({err_mode, in_flight, res_valid} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mode3_flag: got em=%b if=%0d v=%b expected 1/0/0", err_mode, in_flight, res_valid);
    end
    repeat (8) step();
    checks++;
    if (res_valid !== 1'b0 || err_mode !== 1'b1) begin
      errors++; $display("FAIL mode3_noentry: got v=%b em=%b expected 0/1", res_valid, err_mode);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dsp_out = 32'h55;
    mode = 2'd0; pipe_stages = '0; start = 1'b1;
    step();
    mode = 2'd2; pipe_stages = 2'd3;
    repeat (3) step();
    mode = 2'd3;
    step();
    start = 1'b0; mode = 2'd0;
    checks++;
    if ({res_valid, in_flight, err_mode} !== {1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL midrst_pre: got v=%b if=%0d em=%b expected 1/3/1", res_valid, in_flight, err_mode);
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({res_valid, res_data, res_mode, res_mac, in_flight, err_ovf, err_coll, err_mode} !== 43'h0) begin
      errors++;
      $display("FAIL midrst_async: got %h expected 0",
               {res_valid, res_data, res_mode, res_mac, in_flight, err_ovf, err_coll, err_mode});
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (res_valid !== 1'b0 || in_flight !== 4'd0) begin
        errors++;
        $display("FAIL midrst_after%0d: got v=%b if=%0d expected 0/0", i, res_valid, in_flight);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_data;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      start       = ($urandom_range(0, 99) < 60);
      mode        = ($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      mac         = 1'($urandom_range(0, 1));
      pipe_stages = PSW'($urandom_range(0, 3));
      dsp_out     = $urandom;
      res_ready   = ($urandom_range(0, 99) < ((n < 200) ? 30 : 85));
      step();
      exp_data = (fq.size() > 0) ? fq[0].data : 32'h0;
      checks++;
      if (res_valid !== (fq.size() > 0)) begin
        errors++;
        $display("FAIL rand_valid@%0d: got %b expected %b", n, res_valid, fq.size() > 0);
      end
      checks++;
      if (res_data !== exp_data) begin
        errors++;
        $display("FAIL rand_data@%0d: got %h expected %h", n, res_data, exp_data);
      end
      if (fq.size() > 0) begin
        checks++;
        if ({res_mode, res_mac} !== {fq[0].mode, fq[0].mac}) begin
          errors++;
          $display("FAIL rand_tag@%0d: got m=%0d mac=%b expected m=%0d mac=%b",
                   n, res_mode, res_mac, fq[0].mode, fq[0].mac);
        end
      end
      checks++;
      if (in_flight !== 4'(pend.size())) begin
        errors++;
        $display("FAIL rand_inflight@%0d: got %0d expected %0d", n, in_flight, pend.size());
      end
      checks++;
      if ({err_ovf, err_coll, err_mode} !== {m_ovf, m_coll, m_mode}) begin
        errors++;
        $display("FAIL rand_flags@%0d: got %b expected %b", n,
                 {err_ovf, err_coll, err_mode}, {m_ovf, m_coll, m_mode});
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_collision();
    test_overflow();
    test_mode3();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
